aes_round: RTL and testbench

Iterative AES-128 encryption round engine: one AES round per request, with the round key expanded on the fly one step at a time. An external sequencer drives the round number and feeds `o_text` back to `i_text` and `Rkey` back to `key`. The sequencer performs the initial AddRoundKey (plaintext XOR `Rkey`) itself. The block sits between that sequencer and the block-cipher datapath; the cipher key is a build-time parameter.

---
 rtl/aes_round_pkg.sv | 58 +++++
 rtl/aes_round_if.sv | 13 +
 rtl/aes_sbox.sv | 9 +
 rtl/aes_round.sv | 90 +++++++++
 tb/tb_aes_round.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_round_pkg.sv
// Shared AES-128 constants and byte-level helpers for the round engine.
package aes_round_pkg;

  typedef enum logic {ST_IDLE, ST_DONE} state_e;

  localparam logic [127:0] DEFAULT_KEY = 128'h0f0e0d0c0b0a09080706050403020100;

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox_lookup(input logic [7:0] x);
    return SBOX_TBL[{~x, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // Column-major state: s[r][c] lives in byte 4c+r.
  function automatic int sidx(input int r, input int c);
    return 4 * c + r;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // One MixColumns column; 3*a is folded as xtime(a)^a.
  function automatic logic [3:0][7:0] mix_col(input logic [3:0][7:0] a);
    logic [3:0][7:0] b;
    b = '0;
    for (int r = 0; r < 4; r++)
      b[r] = xtime(a[r]) ^ xtime(a[(r + 1) % 4]) ^ a[(r + 1) % 4] ^ a[(r + 2) % 4] ^ a[(r + 3) % 4];
    return b;
  endfunction

endpackage

// File: rtl/aes_round_if.sv
// Sequencer <-> round engine bundle: request side from the sequencer, results back.
interface aes_round_if;
  logic         enable;
  logic [127:0] i_text;
  logic [127:0] key;
  logic [3:0]   round;
  logic [127:0] o_text;
  logic [127:0] Rkey;
  logic         done;

  modport master (output enable, i_text, key, round, input o_text, Rkey, done);
  modport slave  (input enable, i_text, key, round, output o_text, Rkey, done);
endinterface

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte.
module aes_sbox
  import aes_round_pkg::*;
(
  input  logic [7:0] x,
  output logic [7:0] y
);
  assign y = sbox_lookup(x);
endmodule

// File: rtl/aes_round.sv
// Iterative AES-128 round engine: one round per request, round key expanded on the fly.
module aes_round
  import aes_round_pkg::*;
#(
  parameter logic [127:0] CIPHER_KEY = DEFAULT_KEY
) (
  input logic        clk,
  input logic        resetn,
  aes_round_if.slave bus
);

  state_e               state, state_nxt;
  logic [15:0][7:0]     st_in, sb, sr, mc;
  logic [3:0][31:0]     kw, nkw;
  logic [3:0][7:0]      rot, sub_rot, t;
  logic [127:0]         text_r, key_r, text_nxt, key_nxt;
  logic                 ld_text, ld_key;

  assign st_in = bus.i_text;
  assign kw    = bus.key;

  for (genvar i = 0; i < 16; i++) begin : g_state_sbox
    aes_sbox u_sbox (.x(st_in[i]), .y(sb[i]));
  end

  // RotWord puts byte 13 first: {b12, b15, b14, b13} from MSB to LSB.
  assign rot = {kw[3][7:0], kw[3][31:8]};

  for (genvar j = 0; j < 4; j++) begin : g_word_sbox
    aes_sbox u_sbox (.x(rot[j]), .y(sub_rot[j]));
  end

  assign t      = sub_rot ^ {24'h0, rcon(bus.round)};
  assign nkw[0] = kw[0] ^ t;
  assign nkw[1] = kw[1] ^ nkw[0];
  assign nkw[2] = kw[2] ^ nkw[1];
  assign nkw[3] = kw[3] ^ nkw[2];

  always_comb begin
    sr = '0;
    mc = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        sr[sidx(r, c)] = sb[sidx(r, (c + r) % 4)];
    for (int c = 0; c < 4; c++)
      mc[4*c +: 4] = mix_col(sr[4*c +: 4]);
  end

  // Rounds 11-15 still handshake but leave both registers alone.
  always_comb begin
    state_nxt = state;
    ld_text   = 1'b0;
    ld_key    = 1'b0;
    text_nxt  = mc ^ nkw;
    key_nxt   = nkw;
    case (state)
      ST_IDLE: begin
        if (bus.enable) begin
          state_nxt = ST_DONE;
          ld_text   = (bus.round <= 4'd10);
          ld_key    = (bus.round != 4'd0) && (bus.round <= 4'd10);
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
    endcase
    if (bus.round == 4'd0) begin
      text_nxt = bus.i_text;
    end else if (bus.round == 4'd10) begin
      text_nxt = sr ^ nkw;
      key_nxt  = CIPHER_KEY;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state  <= ST_IDLE;
      text_r <= '0;
      key_r  <= CIPHER_KEY;
    end else begin
      state <= state_nxt;
      if (ld_text) text_r <= text_nxt;
      if (ld_key)  key_r  <= key_nxt;
    end
  end

  assign bus.o_text = text_r;
  assign bus.Rkey   = key_r;
  assign bus.done   = (state == ST_DONE);

endmodule

// File: tb/tb_aes_round.sv
// Scoreboarded bench for aes_round against a byte-array AES reference built from GF(2^8) math.
module tb_aes_round;

  localparam logic [127:0] K0 = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] PT = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [127:0] CT = 128'h5ac5b47080b7cdd830047b6ad8e0c469;

  logic clk = 1'b0;
  logic resetn = 1'b0;

  aes_round_if bus ();
  aes_round #(.CIPHER_KEY(K0)) dut (.clk(clk), .resetn(resetn), .bus(bus));

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [7:0]   sbox_m [256];
  logic [7:0]   rcon_m [11];
  logic [127:0] m_otext, m_rkey;
  logic [255:0] sb_q [$];
  logic [255:0] mon_exp;
  logic         prev_done = 1'b0;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p ^= 16'(a) << i;
    for (int i = 15; i >= 8; i--) if (p[i]) p ^= 16'h11b << (i - 8);
    return p[7:0];
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] d;
    d = {v, v} << n;
    return d[15:8];
  endfunction

  // S-box = affine(multiplicative inverse); rcon = successive powers of x.
  function automatic void build_tables();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
    rcon_m[0] = 8'h00;
    rcon_m[1] = 8'h01;
    for (int i = 2; i <= 10; i++) rcon_m[i] = gmul(rcon_m[i-1], 8'h02);
  endfunction

  function automatic logic [127:0] key_expand(input logic [127:0] k, input logic [7:0] rc);
    logic [7:0]   tw [4];
    logic [127:0] nk;
    for (int j = 0; j < 4; j++) tw[j] = sbox_m[k[8*(12 + (j + 1) % 4) +: 8]];
    tw[0] ^= rc;
    nk = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        nk[8*(4*i+j) +: 8] = k[8*(4*i+j) +: 8] ^ ((i == 0) ? tw[j] : nk[8*(4*(i-1)+j) +: 8]);
    return nk;
  endfunction

  function automatic logic [255:0] ref_round(input logic [127:0] txt, input logic [127:0] key,
                                             input int r);
    logic [7:0]   s [4][4];
    logic [7:0]   u [4][4];
    logic [127:0] nk, o;
    for (int c = 0; c < 4; c++)
      for (int rr = 0; rr < 4; rr++) s[rr][c] = sbox_m[txt[8*(4*c+rr) +: 8]];
    for (int c = 0; c < 4; c++)
      for (int rr = 0; rr < 4; rr++) u[rr][c] = s[rr][(c + rr) % 4];
    for (int c = 0; c < 4; c++) begin
      if (r == 10) begin
        for (int rr = 0; rr < 4; rr++) s[rr][c] = u[rr][c];
      end else begin
        s[0][c] = gmul(8'h02, u[0][c]) ^ gmul(8'h03, u[1][c]) ^ u[2][c] ^ u[3][c];
        s[1][c] = u[0][c] ^ gmul(8'h02, u[1][c]) ^ gmul(8'h03, u[2][c]) ^ u[3][c];
        s[2][c] = u[0][c] ^ u[1][c] ^ gmul(8'h02, u[2][c]) ^ gmul(8'h03, u[3][c]);
        s[3][c] = gmul(8'h03, u[0][c]) ^ u[1][c] ^ u[2][c] ^ gmul(8'h02, u[3][c]);
      end
    end
    nk = key_expand(key, rcon_m[r]);
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int rr = 0; rr < 4; rr++) o[8*(4*c+rr) +: 8] = s[rr][c] ^ nk[8*(4*c+rr) +: 8];
    return {o, nk};
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic model_step(input logic [127:0] txt, input logic [127:0] k, input int r);
    logic [255:0] res;
    if (r == 0) begin
      m_otext = txt;
    end else if (r <= 10) begin
      res     = ref_round(txt, k, r);
      m_otext = res[255:128];
      m_rkey  = (r == 10) ? K0 : res[127:0];
    end
    sb_q.push_back({m_otext, m_rkey});
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [127:0] txt, input logic [127:0] k, input logic [3:0] r,
                       output int n);
    bus.i_text = txt;
    bus.key    = k;
    bus.round  = r;
    bus.enable = 1'b1;
    model_step(txt, k, int'(r));
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!bus.done && n < 8);
    if (!bus.done) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: done still 0 after %0d cycles, want 1", n);
    end
  endtask

  task automatic do_reset();
    bus.enable = 1'b0;
    resetn     = 1'b0;
    @(posedge clk); #1;
    resetn  = 1'b1;
    m_otext = '0;
    m_rkey  = K0;
  endtask

  // Sequencer behaviour: whitening, then rounds 0..10 with o_text/Rkey fed back.
  task automatic encrypt_block(input logic [127:0] pt, output int cyc);
    logic [127:0] txt;
    int n;
    cyc = 0;
    txt = pt ^ m_rkey;
    for (int r = 0; r <= 10; r++) begin
      issue(txt, m_rkey, 4'(r), n);
      cyc += n;
      txt = m_otext;
    end
  endtask

  always @(negedge clk) begin
    if (bus.done) begin
      tests++;
      if (prev_done) begin
        fails++;
        $display("FAIL done_pulse: done high on consecutive cycles, want single-cycle pulse");
      end
      tests++;
      if (sb_q.size() == 0) begin
        fails++;
        $display("FAIL scoreboard_empty: done=1 with no outstanding request");
      end else begin
        mon_exp = sb_q.pop_front();
        if ({bus.o_text, bus.Rkey} !== mon_exp) begin
          fails++;
          $display("FAIL scoreboard: got o_text=%h Rkey=%h, want o_text=%h Rkey=%h",
                   bus.o_text, bus.Rkey, mon_exp[255:128], mon_exp[127:0]);
        end
      end
    end
    prev_done = bus.done;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not reach the end, tests=%0d", tests);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, cyc, gap;
    logic [127:0] txt, k;

    build_tables();
    bus.enable = 1'b0;
    bus.i_text = '0;
    bus.key    = '0;
    bus.round  = '0;
    resetn     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_o_text", bus.o_text, 128'h0);
    check("rst_Rkey", bus.Rkey, K0);
    check("rst_done", 128'(bus.done), 128'h0);
    resetn  = 1'b1;
    m_otext = '0;
    m_rkey  = K0;

    // Known-answer rounds 0 and 1
    issue(PT ^ K0, K0, 4'd0, n);
    check("r0_o_text", bus.o_text, 128'hf0e0d0c0b0a090807060504030201000);
    check("r0_Rkey", bus.Rkey, K0);
    check("r0_latency", 128'(n), 128'd1);
    issue(m_otext, m_rkey, 4'd1, n);
    check("r1_o_text", bus.o_text, 128'he48f12cbd843182d68ce5a85e810d889);
    check("r1_Rkey", bus.Rkey, 128'hfe76abd6f178a6dafa72afd2fd74aad6);
    check("r1_latency", 128'(n), 128'd2);
    do_reset();

    // Full FIPS-197 block from idle
    encrypt_block(PT, cyc);
    check("blk_ct", bus.o_text, CT);
    check("blk_Rkey", bus.Rkey, K0);
    bus.enable = 1'b0;
    @(posedge clk); #1;
    cyc++;
    check("blk_cycles", 128'(cyc), 128'd22);
    check("blk_done_low", 128'(bus.done), 128'h0);

    // Two back-to-back blocks with enable never dropped
    encrypt_block(PT, cyc);
    check("b2a_ct", bus.o_text, CT);
    encrypt_block(PT, cyc);
    check("b2b_ct", bus.o_text, CT);
    check("b2b_Rkey", bus.Rkey, K0);
    check("b2b_cycles", 128'(cyc), 128'd22);
    bus.enable = 1'b0;
    @(posedge clk); #1;

    // Held enable, unchanged inputs: one update every two cycles
    txt = rnd128();
    k   = rnd128();
    bus.i_text = txt;
    bus.key    = k;
    bus.round  = 4'd1;
    bus.enable = 1'b1;
    for (int i = 0; i < 3; i++) model_step(txt, k, 1);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("held_done", 128'(bus.done), (i % 2 == 0) ? 128'd1 : 128'd0);
    end
    bus.enable = 1'b0;
    @(posedge clk); #1;

    // Out-of-range round: handshake only
    issue(rnd128(), rnd128(), 4'd12, n);
    check("r12_o_text", bus.o_text, m_otext);
    check("r12_Rkey", bus.Rkey, m_rkey);

    // Reset landing on round 5's compute edge
    do_reset();
    txt = PT ^ m_rkey;
    for (int r = 0; r <= 4; r++) begin
      issue(txt, m_rkey, 4'(r), n);
      txt = m_otext;
    end
    bus.i_text = txt;
    bus.key    = m_rkey;
    bus.round  = 4'd5;
    @(posedge clk); #1;
    resetn = 1'b0;
    @(posedge clk); #1;
    check("rst5_Rkey", bus.Rkey, K0);
    check("rst5_done", 128'(bus.done), 128'h0);
    check("rst5_o_text", bus.o_text, 128'h0);
    resetn     = 1'b1;
    bus.enable = 1'b0;
    m_otext    = '0;
    m_rkey     = K0;

    // Random single rounds, including out-of-range indices and idle gaps
    for (int i = 0; i < 40; i++) begin
      bus.enable = 1'b0;
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        @(posedge clk); #1;
      end
      issue(rnd128(), rnd128(), 4'($urandom_range(0, 15)), n);
    end

    // Random plaintext blocks through the sequencer loop
    for (int i = 0; i < 4; i++) begin
      bus.enable = 1'b0;
      @(posedge clk); #1;
      encrypt_block(rnd128(), cyc);
    end

    bus.enable = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("sb_drain", 128'(sb_q.size()), 128'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
